// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a per-tenure hold limit for the shared processor bus.
// Latency: a request sampled at one edge is granted at the next edge; outputs are registered.
// Backpressure: none; requesters hold req high and wait for their index on grant_idx.
//
// Ports:
//   clk         - single clock, rising edge
//   rst         - asynchronous active-high reset
//   req         - per-requester level-sensitive bus request
//   grant_idx   - encoded index of the current owner (feeds the enable decoder)
//   grant_valid - grant_idx names a real owner; decoder output ignored when low
module bus_arbiter #(
    parameter int N_REQ     = 8,
    parameter int IDX_WIDTH = 3,
    parameter int MAX_HOLD  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 grant_valid
);

    // A one-cycle limit still needs a one-bit counter that simply stays at zero.
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(N_REQ - 1);
    localparam logic [CNT_W-1:0]     HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [IDX_WIDTH:0]   N_WIDE    = (IDX_WIDTH + 1)'(N_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;

    logic [N_REQ-1:0]     owner_mask;
    logic                 owner_req;
    logic [N_REQ-1:0]     others;
    logic [IDX_WIDTH-1:0] next_start;
    logic [IDX_WIDTH:0]   srch_idle;
    logic [IDX_WIDTH:0]   srch_others;

    // (i + 1) mod N_REQ, for i already in 0..N_REQ-1.
    function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_WIDTH'(1);
    endfunction

    // Returns {found, winner}: first set bit of r scanning upward from start,
    // wrapping modulo N_REQ. The doubled vector shifted by start puts the
    // scan origin at bit 0, so the winner is start plus the offset of the
    // lowest set bit.
    function automatic logic [IDX_WIDTH:0] search(input logic [N_REQ-1:0]     r,
                                                  input logic [IDX_WIDTH-1:0] start);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic               found;
        logic [IDX_WIDTH:0] off;
        logic [IDX_WIDTH:0] sum;
        dbl   = {r, r} >> start;
        rot   = dbl[N_REQ-1:0];
        found = 1'b0;
        off   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found) begin
                if (rot[0]) begin
                    found = 1'b1;
                end else begin
                    rot = rot >> 1;
                    off = off + (IDX_WIDTH + 1)'(1);
                end
            end
        end
        sum = {1'b0, start} + off;
        if (sum >= N_WIDE) begin
            sum = sum - N_WIDE;
        end
        return {found, sum[IDX_WIDTH-1:0]};
    endfunction

    always_comb begin
        owner_mask  = N_REQ'(1) << grant_idx_q;
        owner_req   = |(req & owner_mask);
        others      = req & ~owner_mask;
        next_start  = wrap_inc(grant_idx_q);
        srch_idle   = search(req, ptr_q);
        srch_others = search(others, next_start);
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        grant_idx_d = grant_idx_q;

        case (state_q)
            IDLE: begin
                // grant_idx is left alone while idle; only grant_valid drops.
                if (srch_idle[IDX_WIDTH]) begin
                    grant_idx_d = srch_idle[IDX_WIDTH-1:0];
                    hold_cnt_d  = '0;
                    state_d     = OWNED;
                end
            end
            OWNED: begin
                if (!owner_req) begin
                    // Release: hand straight to the next waiter, no idle bus cycle.
                    ptr_d = next_start;
                    if (srch_others[IDX_WIDTH]) begin
                        grant_idx_d = srch_others[IDX_WIDTH-1:0];
                        hold_cnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (hold_cnt_q == HOLD_LAST) begin
                    // Tenure expired: preempt if contended, otherwise the lone
                    // owner keeps the bus and the counter wraps.
                    hold_cnt_d = '0;
                    if (srch_others[IDX_WIDTH]) begin
                        ptr_d       = next_start;
                        grant_idx_d = srch_others[IDX_WIDTH-1:0];
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            grant_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    assign grant_idx   = grant_idx_q;
    assign grant_valid = (state_q == OWNED);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with N_REQ=4, IDX_WIDTH=2, MAX_HOLD=4.
// Each step drives req, queues the grant expected after the next edge, then
// checks it one time unit after that edge.
module tb_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] grant_idx;
    logic       grant_valid;

    int n_tests;
    int n_fail;
    logic [2:0] exp_q[$];

    bus_arbiter #(
        .N_REQ    (4),
        .IDX_WIDTH(2),
        .MAX_HOLD (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic compare(input string tag);
        logic [2:0] e;
        e = exp_q.pop_front();
        n_tests++;
        assert (grant_valid === e[2]) else begin
            n_fail++;
            $error("FAIL %s grant_valid observed=%b expected=%b", tag, grant_valid, e[2]);
        end
        n_tests++;
        assert (grant_idx === e[1:0]) else begin
            n_fail++;
            $error("FAIL %s grant_idx observed=%0d expected=%0d", tag, grant_idx, e[1:0]);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic ev, input logic [1:0] ei,
                        input string tag);
        req = r;
        exp_q.push_back({ev, ei});
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    // Called between edges; returns one unit after an edge with rst released.
    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        #1;
        exp_q.push_back(3'b000);
        compare("reset_async");
        @(posedge clk);
        #1;
        exp_q.push_back(3'b000);
        compare("reset_held");
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        req     = 4'b0000;
        #2;
        do_reset();

        // Single request held 6 cycles, lone timeouts must not drop it.
        for (int c = 0; c < 6; c++) step(4'b0100, 1'b1, 2'd2, "single_hold");
        step(4'b0000, 1'b0, 2'd2, "single_release");
        step(4'b0000, 1'b0, 2'd2, "single_idle");

        // Full contention from reset: 0,1,2,3,0 each for exactly 4 cycles.
        do_reset();
        for (int c = 0; c < 20; c++)
            step(4'b1111, 1'b1, 2'((c / 4) % 4), "full_contention");
        step(4'b0000, 1'b0, 2'd0, "full_release");

        // Lone requester past MAX_HOLD; the counter phase is then exposed by
        // a contender arriving mid-tenure (preempt lands two edges later).
        do_reset();
        for (int c = 0; c < 10; c++) step(4'b0010, 1'b1, 2'd1, "lone_hold");
        step(4'b1010, 1'b1, 2'd1, "lone_wrap_phase");
        step(4'b1010, 1'b1, 2'd1, "lone_wrap_phase");
        step(4'b1010, 1'b1, 2'd3, "lone_then_preempt");
        step(4'b0000, 1'b0, 2'd3, "lone_release");

        // Release handoff with pointer wrap from owner 3 to 0.
        do_reset();
        step(4'b1000, 1'b1, 2'd3, "wrap_own3");
        step(4'b1101, 1'b1, 2'd3, "wrap_pending");
        step(4'b0101, 1'b1, 2'd0, "wrap_handoff");
        step(4'b0101, 1'b1, 2'd0, "wrap_hold0");
        step(4'b0100, 1'b1, 2'd2, "wrap_handoff2");
        step(4'b0000, 1'b0, 2'd2, "wrap_idle");

        // Owner 1 drops while req[3] rises on the same edge.
        step(4'b0010, 1'b1, 2'd1, "simul_own1");
        step(4'b0010, 1'b1, 2'd1, "simul_hold1");
        step(4'b1000, 1'b1, 2'd3, "simul_handoff");
        step(4'b0000, 1'b0, 2'd3, "simul_idle");

        // Owner re-raising right after release queues at lowest priority.
        step(4'b0011, 1'b1, 2'd0, "reraise_own0");
        step(4'b0010, 1'b1, 2'd1, "reraise_handoff");
        step(4'b0011, 1'b1, 2'd1, "reraise_hold");
        step(4'b0011, 1'b1, 2'd1, "reraise_hold");
        step(4'b0011, 1'b1, 2'd1, "reraise_hold");
        step(4'b0011, 1'b1, 2'd0, "reraise_preempt");
        step(4'b0000, 1'b0, 2'd0, "reraise_idle");

        // Asynchronous reset mid-tenure, then restart from ptr=0.
        step(4'b0100, 1'b1, 2'd2, "midrst_own2");
        step(4'b0100, 1'b1, 2'd2, "midrst_hold2");
        #3;
        rst = 1'b1;
        #1;
        exp_q.push_back(3'b000);
        compare("midrst_async");
        @(posedge clk);
        #1;
        exp_q.push_back(3'b000);
        compare("midrst_held");
        rst = 1'b0;
        for (int c = 0; c < 4; c++) step(4'b0110, 1'b1, 2'd1, "post_rst_first");
        step(4'b0110, 1'b1, 2'd2, "post_rst_preempt");
        step(4'b0000, 1'b0, 2'd2, "post_rst_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
